// File: rtl/memstage.sv
// memstage: RV32I load/store stage. It keeps one op in flight and talks to data memory over a req/gnt/rvalid handshake.
// Optional define MEMSTAGE_MISALIGN_TRAP_EN traps misaligned H/W accesses instead of issuing them.
module memstage #(
  parameter int unsigned DMEM_AW = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               ex_valid_i,
  output logic               ex_ready_o,
  input  logic [1:0]         mem_op_i,
  input  logic [2:0]         funct3_i,
  input  logic [31:0]        alu_result_i,
  input  logic [31:0]        store_data_i,
  input  logic [4:0]         rd_addr_i,
  input  logic               reg_we_i,
  output logic               wb_valid_o,
  input  logic               wb_ready_i,
  output logic [31:0]        wb_data_o,
  output logic [4:0]         wb_rd_addr_o,
  output logic               wb_reg_we_o,
  output logic               dmem_req_o,
  output logic               dmem_we_o,
  output logic [DMEM_AW-1:0] dmem_addr_o,
  output logic [3:0]         dmem_be_o,
  output logic [31:0]        dmem_wdata_o,
  input  logic               dmem_gnt_i,
  input  logic               dmem_rvalid_i,
  input  logic [31:0]        dmem_rdata_i,
  output logic               misaligned_o
);

  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;

  state_e      state_q;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [1:0]  lane_q;

  logic        accept;
  logic        is_load;
  logic        is_store;
  logic        is_mem;
  logic        misalign;
  logic [1:0]  lane_d;
  logic [31:0] load_data_d;

  // Byte offset of the accessed lane; bits below the access size are ignored.
  function automatic logic [1:0] lane_off(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   return a;
      2'b01:   return {a[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] lane);
    case (f3[1:0])
      2'b00:   return 4'b0001 << lane;
      2'b01:   return 4'b0011 << lane;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_rep(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  // Shift the addressed lane down, then sign- or zero-extend by funct3[2].
  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] lane,
                                           input logic [31:0] word);
    logic [31:0] sh;
    logic        sx;
    sh = word >> {lane, 3'b000};
    sx = ~f3[2];
    case (f3[1:0])
      2'b00:   return {{24{sx & sh[7]}}, sh[7:0]};
      2'b01:   return {{16{sx & sh[15]}}, sh[15:0]};
      default: return sh;
    endcase
  endfunction

  assign ex_ready_o  = (state_q == S_IDLE) || ((state_q == S_DONE) && wb_ready_i);
  assign accept      = ex_valid_i && ex_ready_o;
  assign is_load     = (mem_op_i == OP_LOAD);
  assign is_store    = (mem_op_i == OP_STORE);
  assign is_mem      = is_load || is_store;
  assign lane_d      = lane_off(funct3_i, alu_result_i[1:0]);
  assign load_data_d = load_ext(funct3_q, lane_q, dmem_rdata_i);

`ifdef MEMSTAGE_MISALIGN_TRAP_EN
  assign misalign = is_mem &&
                    (((funct3_i[1:0] == 2'b01) && alu_result_i[0]) ||
                     (funct3_i[1] && (alu_result_i[1:0] != 2'b00)));
`else
  assign misalign = 1'b0;
`endif

  // Stage FSM. A new op accepted in the same cycle overrides the DONE-to-IDLE move.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      we_q         <= 1'b0;
      funct3_q     <= 3'b000;
      lane_q       <= 2'b00;
      wb_valid_o   <= 1'b0;
      wb_data_o    <= 32'd0;
      wb_rd_addr_o <= 5'd0;
      wb_reg_we_o  <= 1'b0;
      dmem_req_o   <= 1'b0;
      dmem_we_o    <= 1'b0;
      dmem_addr_o  <= '0;
      dmem_be_o    <= 4'b0000;
      dmem_wdata_o <= 32'd0;
      misaligned_o <= 1'b0;
    end else begin
      case (state_q)
        S_REQ: begin
          if (dmem_gnt_i) begin
            dmem_req_o <= 1'b0;
            if (dmem_we_o) begin
              state_q     <= S_DONE;
              wb_valid_o  <= 1'b1;
              wb_reg_we_o <= 1'b0;
              wb_data_o   <= 32'd0;
            end else if (dmem_rvalid_i) begin
              state_q     <= S_DONE;
              wb_valid_o  <= 1'b1;
              wb_reg_we_o <= we_q;
              wb_data_o   <= load_data_d;
            end else begin
              state_q <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (dmem_rvalid_i) begin
            state_q     <= S_DONE;
            wb_valid_o  <= 1'b1;
            wb_reg_we_o <= we_q;
            wb_data_o   <= load_data_d;
          end
        end
        S_DONE: begin
          if (wb_ready_i) begin
            state_q    <= S_IDLE;
            wb_valid_o <= 1'b0;
          end
        end
        default: ;
      endcase

      if (accept) begin
        wb_rd_addr_o <= rd_addr_i;
        we_q         <= reg_we_i;
        funct3_q     <= funct3_i;
        lane_q       <= lane_d;
        misaligned_o <= 1'b0;
        if (!is_mem) begin
          state_q     <= S_DONE;
          wb_valid_o  <= 1'b1;
          wb_data_o   <= alu_result_i;
          wb_reg_we_o <= reg_we_i;
        end else if (misalign) begin
          state_q      <= S_DONE;
          wb_valid_o   <= 1'b1;
          wb_data_o    <= alu_result_i;
          wb_reg_we_o  <= 1'b0;
          misaligned_o <= 1'b1;
        end else begin
          state_q      <= S_REQ;
          wb_valid_o   <= 1'b0;
          wb_reg_we_o  <= 1'b0;
          dmem_req_o   <= 1'b1;
          dmem_we_o    <= is_store;
          dmem_addr_o  <= DMEM_AW'({alu_result_i[31:2], 2'b00});
          dmem_be_o    <= byte_en(funct3_i, lane_d);
          dmem_wdata_o <= store_rep(funct3_i, store_data_i);
        end
      end
    end
  end

endmodule

// File: tb/tb_memstage.sv
// Scoreboard bench for memstage: directed corner cases then random ops against a byte-level reference model.
module tb_memstage;

  logic        clk_i, rst_i;
  logic        ex_valid_i, ex_ready_o;
  logic [1:0]  mem_op_i;
  logic [2:0]  funct3_i;
  logic [31:0] alu_result_i, store_data_i;
  logic [4:0]  rd_addr_i;
  logic        reg_we_i;
  logic        wb_valid_o, wb_ready_i;
  logic [31:0] wb_data_o;
  logic [4:0]  wb_rd_addr_o;
  logic        wb_reg_we_o;
  logic        dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_gnt_i, dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;
  logic        misaligned_o;

  memstage #(.DMEM_AW(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o),
    .mem_op_i(mem_op_i), .funct3_i(funct3_i),
    .alu_result_i(alu_result_i), .store_data_i(store_data_i),
    .rd_addr_i(rd_addr_i), .reg_we_i(reg_we_i),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
    .wb_data_o(wb_data_o), .wb_rd_addr_o(wb_rd_addr_o), .wb_reg_we_o(wb_reg_we_o),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
    .misaligned_o(misaligned_o)
  );

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        we;
    logic        mis;
    bit          chk_data;
  } wb_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
  } rq_t;

  wb_t wbq[$];
  rq_t reqq[$];
  int  pop_cycles[$];
  logic [31:0] model_mem [logic [31:0]];
  logic [31:0] slave_mem [logic [31:0]];

  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  req_count = 0;
  int  gnt_dly = -1;
  int  rv_dly = -1;
  int  hold_left = 0;
  bit  ready_mode = 1'b0;
  wb_t last_wb;
  rq_t last_req;

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    return model_mem.exists(a) ? model_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] slave_read(input logic [31:0] a);
    return slave_mem.exists(a) ? slave_mem[a] : init_word(a);
  endfunction

  // Reference model: expected bus request and writeback from size, offset and memory image.
  task automatic predict(input logic [1:0] op, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d, input logic [4:0] rd, input logic we);
    wb_t w;
    rq_t r;
    int nb, off, ao;
    bit sgn, mis;
    logic [31:0] word, v, mask;
    nb  = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
    sgn = (f3 == 3'd0 || f3 == 3'd1);
    ao  = int'(a % 32'd4);
    off = (ao / nb) * nb;
`ifdef MEMSTAGE_MISALIGN_TRAP_EN
    mis = (ao % nb) != 0;
`else
    mis = 1'b0;
`endif
    w.rd = rd; w.we = we; w.mis = 1'b0; w.data = 32'd0; w.chk_data = 1'b1;
    if (op == 2'd0 || op == 2'd3) begin
      w.data = a;
    end else if (mis) begin
      w.we = 1'b0; w.mis = 1'b1; w.chk_data = 1'b0;
    end else begin
      r.addr = a - (a % 32'd4);
      r.be   = 4'(((1 << nb) - 1) << off);
      r.we   = (op == 2'd2);
      for (int b = 0; b < 4; b++) r.wdata[8*b +: 8] = d[8*(b % nb) +: 8];
      reqq.push_back(r);
      if (op == 2'd2) begin
        word = model_read(r.addr);
        for (int b = 0; b < 4; b++) if (r.be[b]) word[8*b +: 8] = r.wdata[8*b +: 8];
        model_mem[r.addr] = word;
        w.we = 1'b0; w.chk_data = 1'b0;
      end else begin
        v = model_read(r.addr) >> (8 * off);
        if (nb < 4) begin
          mask = (32'd1 << (8 * nb)) - 32'd1;
          v = v & mask;
          if (sgn && v[8*nb-1]) v = v | ~mask;
        end
        w.data = v;
      end
    end
    wbq.push_back(w);
  endtask

  task automatic issue(input logic [1:0] op, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, input logic [4:0] rd, input logic we);
    int n;
    @(negedge clk_i);
    ex_valid_i = 1'b1; mem_op_i = op; funct3_i = f3; alu_result_i = a;
    store_data_i = d; rd_addr_i = rd; reg_we_i = we;
    for (n = 0; n < 200; n++) begin
      #1;
      if (wbq.size() == 0) chk("ex_ready_when_idle", 32'(ex_ready_o), 32'd1);
      if (ex_ready_o) break;
      @(negedge clk_i);
    end
    if (n >= 200) begin
      chk("issue_timeout", 32'(ex_ready_o), 32'd1);
    end else begin
      predict(op, f3, a, d, rd, we);
      @(posedge clk_i);
      #1;
    end
    ex_valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (wbq.size() != 0 && n < 300) begin
      @(negedge clk_i);
      n++;
    end
    chk("drain_pending", 32'(wbq.size()), 32'd0);
    if (wbq.size() != 0) begin
      wbq.delete();
      reqq.delete();
    end
    @(negedge clk_i);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_wb_valid"},  32'(wb_valid_o),   32'd0);
    chk({tag, "_dmem_req"},  32'(dmem_req_o),   32'd0);
    chk({tag, "_dmem_we"},   32'(dmem_we_o),    32'd0);
    chk({tag, "_wb_we"},     32'(wb_reg_we_o),  32'd0);
    chk({tag, "_misalign"},  32'(misaligned_o), 32'd0);
    chk({tag, "_be"},        32'(dmem_be_o),    32'd0);
    chk({tag, "_wb_data"},   wb_data_o,         32'd0);
    chk({tag, "_addr"},      dmem_addr_o,       32'd0);
    chk({tag, "_wdata"},     dmem_wdata_o,      32'd0);
  endtask

  // Writeback consumer.
  initial begin : wb_driver
    forever begin
      @(negedge clk_i);
      if (hold_left > 0 && wb_valid_o) begin
        wb_ready_i = 1'b0;
        hold_left--;
      end else begin
        wb_ready_i = ready_mode ? 1'b1 : ($urandom_range(0, 3) != 0);
      end
    end
  end

  // Data-memory slave with configurable grant and read-data latency, plus stray strobes when idle.
  initial begin : responder
    int gcnt, rcnt;
    bit rpend, in_req;
    logic [31:0] rword, w;
    gcnt = 0; rcnt = 0; rpend = 1'b0; in_req = 1'b0; rword = 32'd0;
    forever begin
      @(negedge clk_i);
      dmem_gnt_i = 1'b0;
      dmem_rvalid_i = 1'b0;
      if (!dmem_req_o) in_req = 1'b0;
      if (rpend) begin
        if (rcnt == 0) begin
          dmem_rvalid_i = 1'b1; dmem_rdata_i = rword; rpend = 1'b0;
        end else begin
          rcnt--;
        end
      end else if (dmem_req_o) begin
        if (!in_req) begin
          in_req = 1'b1;
          gcnt = (gnt_dly < 0) ? int'($urandom_range(0, 3)) : gnt_dly;
        end
        if (gcnt == 0) begin
          dmem_gnt_i = 1'b1;
          in_req = 1'b0;
          if (dmem_we_o) begin
            w = slave_read(dmem_addr_o);
            for (int b = 0; b < 4; b++) if (dmem_be_o[b]) w[8*b +: 8] = dmem_wdata_o[8*b +: 8];
            slave_mem[dmem_addr_o] = w;
          end else begin
            rword = slave_read(dmem_addr_o);
            rcnt = (rv_dly < 0) ? int'($urandom_range(0, 3)) : rv_dly;
            if (rcnt == 0) begin
              dmem_rvalid_i = 1'b1; dmem_rdata_i = rword;
            end else begin
              rpend = 1'b1; rcnt--;
            end
          end
        end else begin
          gcnt--;
        end
      end else if ($urandom_range(0, 3) == 0) begin
        dmem_gnt_i = 1'b1; dmem_rvalid_i = 1'b1; dmem_rdata_i = $urandom;
      end
    end
  end

  // Monitor: compares bus requests and writebacks against the scoreboard queues.
  initial begin : monitor
    rq_t r;
    wb_t w;
    forever begin
      @(negedge clk_i);
      #3;
      cyc++;
      if (rst_i) continue;
      if (dmem_req_o) begin
        if (reqq.size() == 0) begin
          chk("dmem_req_unexpected", 32'(dmem_req_o), 32'd0);
        end else begin
          r = reqq[0];
          chk("dmem_addr", dmem_addr_o, r.addr);
          chk("dmem_be", 32'(dmem_be_o), 32'(r.be));
          chk("dmem_we", 32'(dmem_we_o), 32'(r.we));
          if (r.we) chk("dmem_wdata", dmem_wdata_o, r.wdata);
          if (dmem_gnt_i) begin
            last_req.addr = dmem_addr_o; last_req.be = dmem_be_o;
            last_req.we = dmem_we_o; last_req.wdata = dmem_wdata_o;
            void'(reqq.pop_front());
            req_count++;
          end
        end
      end
      if (wb_valid_o) begin
        if (wbq.size() == 0) begin
          chk("wb_valid_unexpected", 32'(wb_valid_o), 32'd0);
        end else begin
          w = wbq[0];
          chk("wb_rd_addr", 32'(wb_rd_addr_o), 32'(w.rd));
          chk("wb_reg_we", 32'(wb_reg_we_o), 32'(w.we));
          chk("misaligned", 32'(misaligned_o), 32'(w.mis));
          if (w.chk_data) chk("wb_data", wb_data_o, w.data);
          if (wb_ready_i) begin
            last_wb.data = wb_data_o; last_wb.rd = wb_rd_addr_o;
            last_wb.we = wb_reg_we_o; last_wb.mis = misaligned_o;
            void'(wbq.pop_front());
            pop_cycles.push_back(cyc);
          end else begin
            chk("ex_ready_while_stalled", 32'(ex_ready_o), 32'd0);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got running expected finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int k0, rc, n;
    int f3s[5];
    logic [1:0] op;
    f3s = '{0, 1, 2, 4, 5};
    ex_valid_i = 1'b0; mem_op_i = 2'd0; funct3_i = 3'd0; alu_result_i = 32'd0;
    store_data_i = 32'd0; rd_addr_i = 5'd0; reg_we_i = 1'b0; wb_ready_i = 1'b0;
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = 32'd0;
    rst_i = 1'b0;
    #1 rst_i = 1'b1;
    #11;
    chk_zero("reset");
    chk("reset_ex_ready", 32'(ex_ready_o), 32'd1);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;

    // SW with grant one cycle late.
    gnt_dly = 1; rv_dly = -1; ready_mode = 1'b0;
    issue(2'd2, 3'd2, 32'h104, 32'hDEADBEEF, 5'd3, 1'b1);
    wait_idle();
    chk("sw_be", 32'(last_req.be), 32'hF);
    chk("sw_addr", last_req.addr, 32'h104);
    chk("sw_wdata", last_req.wdata, 32'hDEADBEEF);
    chk("sw_wb_we", 32'(last_wb.we), 32'd0);

    // LB / LBU on a negative byte.
    gnt_dly = -1;
    issue(2'd2, 3'd2, 32'h200, 32'h80123456, 5'd1, 1'b0);
    issue(2'd1, 3'd0, 32'h203, 32'd0, 5'd4, 1'b1);
    wait_idle();
    chk("lb_sext", last_wb.data, 32'hFFFFFF80);
    issue(2'd1, 3'd4, 32'h203, 32'd0, 5'd5, 1'b1);
    wait_idle();
    chk("lbu_zext", last_wb.data, 32'h00000080);

    // SH to upper half.
    issue(2'd2, 3'd1, 32'h12, 32'h0000ABCD, 5'd2, 1'b0);
    wait_idle();
    chk("sh_be", 32'(last_req.be), 32'hC);
    chk("sh_wdata", last_req.wdata, 32'hABCDABCD);

    // LH with grant and rvalid together, writeback stalled three cycles.
    gnt_dly = 0; rv_dly = 0; hold_left = 3;
    issue(2'd1, 3'd1, 32'h202, 32'd0, 5'd9, 1'b1);
    wait_idle();
    chk("lh_sext", last_wb.data, 32'hFFFF8012);
    chk("lh_hold_consumed", 32'(hold_left), 32'd0);

    // Back-to-back non-memory ops.
    ready_mode = 1'b1;
    k0 = pop_cycles.size();
    for (int i = 0; i < 4; i++) issue(2'd0, 3'd0, 32'h55, 32'd0, 5'd7, 1'b1);
    wait_idle();
    chk("b2b_count", 32'(pop_cycles.size() - k0), 32'd4);
    if (pop_cycles.size() >= k0 + 4)
      for (int i = 1; i < 4; i++)
        chk("b2b_spacing", 32'(pop_cycles[k0+i] - pop_cycles[k0+i-1]), 32'd1);
    chk("b2b_data", last_wb.data, 32'h55);
    chk("b2b_rd", 32'(last_wb.rd), 32'd7);

    // LW at 0x2.
    rc = req_count;
    issue(2'd1, 3'd2, 32'h2, 32'd0, 5'd6, 1'b1);
    wait_idle();
`ifdef MEMSTAGE_MISALIGN_TRAP_EN
    chk("lw_mis_flag", 32'(last_wb.mis), 32'd1);
    chk("lw_mis_no_req", 32'(req_count - rc), 32'd0);
    chk("lw_mis_we", 32'(last_wb.we), 32'd0);
`else
    chk("lw_mis_flag", 32'(last_wb.mis), 32'd0);
    chk("lw_low_req", 32'(req_count - rc), 32'd1);
    chk("lw_low_addr", last_req.addr, 32'h0);
`endif

    // Reset while waiting for read data; the late rvalid must be dropped.
    ready_mode = 1'b0; gnt_dly = 0; rv_dly = 6;
    rc = req_count;
    issue(2'd1, 3'd2, 32'h100, 32'd0, 5'd8, 1'b1);
    n = 0;
    while (req_count == rc && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    chk("wait_grant_seen", 32'(req_count - rc), 32'd1);
    rst_i = 1'b1;
    wbq.delete();
    reqq.delete();
    #1;
    chk_zero("reset_in_wait");
    @(negedge clk_i);
    rst_i = 1'b0;
    repeat (10) @(negedge clk_i);
    chk("post_reset_no_wb", 32'(wb_valid_o), 32'd0);
    chk("post_reset_ready", 32'(ex_ready_o), 32'd1);

    // Random traffic.
    gnt_dly = -1; rv_dly = -1;
    for (int i = 0; i < 300; i++) begin
      if (i % 50 == 0) ready_mode = ($urandom_range(0, 1) == 1);
      op = 2'($urandom_range(0, 3));
      issue(op, 3'(f3s[$urandom_range(0, 4)]), 32'h100 + 32'($urandom_range(0, 63)),
            $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(negedge clk_i);
    end
    wait_idle();
    chk("final_req_queue", 32'(reqq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
